board_object_scanner: RTL and testbench
=======================================

Name: board_object_scanner

Overview:
- Downstream consumer of the object memory that the new-game coordinator loads with a 105-entry board.
- On the coordinator's new_game_ready pulse, the block scans object-memory addresses 0..104 through a 1-cycle-latency read port.
- Every non-empty entry is decoded into a draw command and pushed to the tile renderer over a valid/ready handshake.
- At the end of a full pass it reports the number of objects found.

Parameters:
- DEPTH, 105, number of object-memory entries scanned per pass
- ADDR_W, 7, object-memory address width
- DATA_W, 11, object-memory word width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse (new_game_ready) that begins a scan
- hold  in  1  coordinator `resetting` flag; high means object memory is being rewritten
- address_read_om  out  ADDR_W  object-memory read address
- data_read_om  in  DATA_W  object-memory read data, valid one cycle after the address is presented
- cmd_valid  out  1  draw command valid
- cmd_ready  in  1  renderer accepts the command
- cmd_addr  out  ADDR_W  board cell index of the command
- cmd_kind  out  3  word[10:8]; 0 means numeric entry
- cmd_value  out  7  word[6:0]
- busy  out  1  high while a scan is active
- done  out  1  one-cycle pulse when a scan completes
- object_count  out  7  non-empty entries emitted in the last completed scan

Behaviour:
- Reset values: every output is 0 and the state is IDLE.
- Word decode:
  - An entry is empty when the word is 0.
  - kind = word[10:8]; value = word[6:0]; bit 7 is ignored.
- States:
  - IDLE: busy=0.
    - If start=1 and hold=0, then address_read_om<=0, clear the running count, busy<=1, go to ISSUE.
    - A start pulse that arrives while hold=1 is dropped.
  - ISSUE: the address is stable on address_read_om. Go to CAPTURE.
  - CAPTURE: register data_read_om.
    - Non-empty word: load cmd_addr/kind/value, cmd_valid<=1, go to EMIT.
    - Empty word at the last address: go to FINISH.
    - Empty word otherwise: address+1, go to ISSUE.
  - EMIT: hold cmd_* stable while cmd_valid=1 and cmd_ready=0.
    - On cmd_valid & cmd_ready: cmd_valid<=0, running count+1.
    - If the address is DEPTH-1, go to FINISH. Otherwise address+1 and go to ISSUE.
  - FINISH: done<=1 for one cycle, object_count<=running count, busy<=0, go to IDLE.
- Timing:
  - Empty entries cost 2 cycles each.
  - Non-empty entries cost 2 cycles plus the EMIT cycles; EMIT lasts at least 1 cycle.
  - With all-zero memory and start sampled in cycle 0, done is high in cycle 211 only.
- Command handshake:
  - cmd_* must not change while cmd_valid=1 and the command is unaccepted.
  - The command register is a single entry with no buffering; the next read is not issued until acceptance.
- Address limits: the address never exceeds DEPTH-1 and never wraps; the scan ends after exactly DEPTH reads.
- Abort: hold=1 in any non-IDLE state takes effect on the next edge.
  - Go to IDLE with cmd_valid=0 and busy=0. No done pulse.
  - object_count keeps its previous value.
- Overlapping starts:
  - start while busy is ignored.
  - start in the FINISH cycle is ignored.
- Reset mid-scan: the next edge returns the block to the full reset values and discards any pending command.
- Width: the running count is 7 bits; at most 105, so it never overflows.

Decomposition:
- Shared package: DEPTH, ADDR_W, DATA_W; the state encoding (IDLE, ISSUE, CAPTURE, EMIT, FINISH); the KIND_NUMERIC=0 constant.
- No sub-module needed; the FSM and the single command register live in one module.

Test Plan:
- All-zero memory, start in cycle 0 -> no cmd_valid; done high only in cycle 211; object_count=0; address_read_om ends at 104.
- Entry 0=0x00A and entry 104=0x300, cmd_ready tied high -> exactly two commands:
  - (addr 0, kind 0, value 10)
  - (addr 104, kind 3, value 0)
  - then done with object_count=2.
- Entry 5=0x17F, cmd_ready low for 6 cycles -> cmd_valid=1 with cmd_addr=5, kind=1, value=127 held stable across all 6 cycles; address_read_om stays 5; a single acceptance follows.
- All 105 entries non-empty, cmd_ready high -> 105 commands with addresses 0..104 in order; object_count=105; done once.
- hold raised while in EMIT at addr 40 -> next cycle cmd_valid=0 and busy=0; no done; object_count unchanged. A new start with hold=0 then rescans from addr 0.
- start pulsed again at cycle 50 of an active scan, and start pulsed with hold=1 -> both ignored (no restart, no scan); reset at cycle 100 -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/board_object_scanner_pkg.sv
// board_object_scanner_pkg: shared sizes, FSM state encoding and kind constants for the object scanner.
package board_object_scanner_pkg;
  localparam int DEPTH = 105;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 11;
  localparam logic [2:0] KIND_NUMERIC = 3'd0;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_EMIT, S_FINISH} state_t;
endpackage

// File: rtl/board_object_scanner.sv
// board_object_scanner: walks the object memory once per start and emits a draw command per non-empty entry.
module board_object_scanner
  import board_object_scanner_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hold,
  output logic [ADDR_W-1:0] address_read_om,
  input  logic [DATA_W-1:0] data_read_om,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [2:0]        cmd_kind,
  output logic [6:0]        cmd_value,
  output logic              busy,
  output logic              done,
  output logic [6:0]        object_count
);
  state_t r_state;
  logic [ADDR_W-1:0] r_addr, r_cmd_addr;
  logic [2:0] r_cmd_kind;
  logic [6:0] r_cmd_value, r_count, r_object_count;
  logic r_cmd_valid, r_busy, r_done;
  logic w_last, w_empty;
  assign w_last = r_addr == ADDR_W'(DEPTH - 1);
  // bit 7 alone still marks the entry as present
  assign w_empty = data_read_om[10:8] == KIND_NUMERIC && data_read_om[7:0] == 8'd0;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr <= '0;
      r_cmd_addr <= '0;
      r_cmd_kind <= '0;
      r_cmd_value <= '0;
      r_count <= '0;
      r_object_count <= '0;
      r_cmd_valid <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (hold && r_state != S_IDLE) begin
        r_state <= S_IDLE;
        r_cmd_valid <= 1'b0;
        r_busy <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (start && !hold) begin
            r_addr <= '0;
            r_count <= '0;
            r_busy <= 1'b1;
            r_state <= S_ISSUE;
          end
          S_ISSUE: r_state <= S_CAPTURE;
          S_CAPTURE: if (!w_empty) begin
            r_cmd_addr <= r_addr;
            r_cmd_kind <= data_read_om[10:8];
            r_cmd_value <= data_read_om[6:0];
            r_cmd_valid <= 1'b1;
            r_state <= S_EMIT;
          end else if (w_last) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
            r_object_count <= r_count;
            r_state <= S_FINISH;
          end else begin
            r_addr <= r_addr + 1'b1;
            r_state <= S_ISSUE;
          end
          S_EMIT: if (r_cmd_valid && cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_count <= r_count + 7'd1;
            if (w_last) begin
              r_done <= 1'b1;
              r_busy <= 1'b0;
              r_object_count <= r_count + 7'd1;
              r_state <= S_FINISH;
            end else begin
              r_addr <= r_addr + 1'b1;
              r_state <= S_ISSUE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
  assign address_read_om = r_addr;
  assign cmd_valid = r_cmd_valid;
  assign cmd_addr = r_cmd_addr;
  assign cmd_kind = r_cmd_kind;
  assign cmd_value = r_cmd_value;
  assign busy = r_busy;
  assign done = r_done;
  assign object_count = r_object_count;
endmodule

// File: tb/tb_board_object_scanner.sv
// tb_board_object_scanner: directed scans against a memory-derived command queue and hand-computed timings.
module tb_board_object_scanner;
  import board_object_scanner_pkg::*;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, hold = 1'b0, cmd_ready = 1'b0;
  logic [ADDR_W-1:0] address_read_om, cmd_addr;
  logic [DATA_W-1:0] data_read_om = '0;
  logic cmd_valid, busy, done;
  logic [2:0] cmd_kind;
  logic [6:0] cmd_value, object_count;
  logic [DATA_W-1:0] mem [DEPTH];
  typedef struct {int a; int k; int v;} cmd_t;
  cmd_t exp_q[$], got_q[$];
  int errors = 0, checks = 0;
  int edge_cnt = 0, t0 = 0, exp_cnt = 0;
  int n_valid = 0, n_acc = 0, n_done = 0, done_cyc = -1;
  logic p_pend = 1'b0, p_hold = 1'b0, p_rst = 1'b1;
  logic [ADDR_W-1:0] p_a;
  logic [2:0] p_k;
  logic [6:0] p_v;

  board_object_scanner dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .address_read_om(address_read_om), .data_read_om(data_read_om),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_kind(cmd_kind), .cmd_value(cmd_value), .busy(busy), .done(done),
    .object_count(object_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;
  always @(posedge clk) data_read_om <= (int'(address_read_om) < DEPTH) ? mem[address_read_om] : '0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Scoreboard: every accepted command must be the next non-empty memory entry in address order.
  always @(negedge clk) begin
    if (!reset) chk("addr_range", int'(address_read_om <= ADDR_W'(DEPTH - 1)), 1);
    if (p_pend && !p_hold && !p_rst) begin
      chk("stall_valid", cmd_valid, 1);
      chk("stall_addr", cmd_addr, p_a);
      chk("stall_kind", cmd_kind, p_k);
      chk("stall_value", cmd_value, p_v);
    end
    if (cmd_valid) n_valid++;
    if (cmd_valid && cmd_ready && !hold && !reset) begin
      n_acc++;
      got_q.push_back('{int'(cmd_addr), int'(cmd_kind), int'(cmd_value)});
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_cmd: got addr %0d, expected no command", cmd_addr);
      end else begin
        cmd_t e;
        e = exp_q.pop_front();
        if (e.a != int'(cmd_addr) || e.k != int'(cmd_kind) || e.v != int'(cmd_value)) begin
          errors++;
          $display("FAIL cmd: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                   cmd_addr, cmd_kind, cmd_value, e.a, e.k, e.v);
        end
      end
    end
    if (done && !reset) begin
      n_done++;
      done_cyc = edge_cnt - t0;
      chk("done_object_count", object_count, exp_cnt);
      chk("done_queue_drained", exp_q.size(), 0);
    end
    p_pend = cmd_valid && !cmd_ready;
    p_hold = hold;
    p_rst = reset;
    p_a = cmd_addr;
    p_k = cmd_kind;
    p_v = cmd_value;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  endtask

  task automatic arm_model;
    exp_q.delete();
    got_q.delete();
    exp_cnt = 0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i] != 0) begin
        exp_q.push_back('{i, int'(mem[i][10:8]), int'(mem[i][6:0])});
        exp_cnt++;
      end
  endtask

  task automatic pulse_start(input bit h);
    start = 1'b1;
    hold = h;
    t0 = edge_cnt;
    tick;
    start = 1'b0;
    hold = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    while (k < budget) begin
      @(negedge clk);
      if (done) break;
      k++;
    end
    if (k >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s: done not seen within %0d cycles", name, budget);
    end
    tick;
  endtask

  task automatic wait_valid(input int budget, input string name);
    int k;
    k = 0;
    while (k < budget) begin
      @(negedge clk);
      if (cmd_valid) break;
      k++;
    end
    if (k >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s: cmd_valid not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_address"}, address_read_om, 0);
    chk({tag, "_cmd_valid"}, cmd_valid, 0);
    chk({tag, "_cmd_addr"}, cmd_addr, 0);
    chk({tag, "_cmd_kind"}, cmd_kind, 0);
    chk({tag, "_cmd_value"}, cmd_value, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_object_count"}, object_count, 0);
  endtask

  initial begin
    int a0, v0, d0;
    clear_mem;
    tick;
    tick;
    chk_zero_outputs("reset");
    reset = 1'b0;
    tick;

    // all-zero memory: 105 reads at 2 cycles each, done in cycle 211
    arm_model;
    v0 = n_valid;
    d0 = n_done;
    pulse_start(1'b0);
    wait_done(400, "zero_scan");
    chk("zero_done_cycle", done_cyc, 211);
    chk("zero_object_count", object_count, 0);
    chk("zero_last_addr", address_read_om, 104);
    chk("zero_no_valid", n_valid - v0, 0);
    chk("zero_done_pulse_low", done, 0);
    chk("zero_busy_low", busy, 0);
    repeat (3) tick;
    chk("zero_done_once", n_done - d0, 1);

    // first and last cells populated, renderer always ready
    mem[0] = 11'h00A;
    mem[104] = 11'h300;
    cmd_ready = 1'b1;
    arm_model;
    pulse_start(1'b0);
    wait_done(500, "ends_scan");
    chk("ends_done_cycle", done_cyc, 213);
    chk("ends_cmd_total", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk("ends_c0_addr", got_q[0].a, 0);
      chk("ends_c0_kind", got_q[0].k, 0);
      chk("ends_c0_value", got_q[0].v, 10);
      chk("ends_c1_addr", got_q[1].a, 104);
      chk("ends_c1_kind", got_q[1].k, 3);
      chk("ends_c1_value", got_q[1].v, 0);
    end
    chk("ends_object_count", object_count, 2);

    // backpressure on a single command
    clear_mem;
    mem[5] = 11'h17F;
    cmd_ready = 1'b0;
    arm_model;
    a0 = n_acc;
    pulse_start(1'b0);
    wait_valid(100, "stall_wait");
    for (int i = 0; i < 6; i++) begin
      chk("stall_v", cmd_valid, 1);
      chk("stall_a", cmd_addr, 5);
      chk("stall_k", cmd_kind, 1);
      chk("stall_val", cmd_value, 127);
      chk("stall_read_addr", address_read_om, 5);
      if (i < 5) @(negedge clk);
    end
    tick;
    cmd_ready = 1'b1;
    wait_done(500, "stall_scan");
    chk("stall_accepts", n_acc - a0, 1);
    chk("stall_done_cycle", done_cyc, 218);
    chk("stall_object_count", object_count, 1);

    // every cell populated, bit 7 toggling and all kinds exercised
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(((i % 8) << 8) | ((i % 2) << 7) | (i + 1));
    arm_model;
    a0 = n_acc;
    d0 = n_done;
    pulse_start(1'b0);
    wait_done(1000, "full_scan");
    chk("full_done_cycle", done_cyc, 316);
    chk("full_accepts", n_acc - a0, 105);
    chk("full_object_count", object_count, 105);
    if (got_q.size() == 105) chk("full_last_addr", got_q[104].a, 104);
    repeat (3) tick;
    chk("full_done_once", n_done - d0, 1);

    // abort while a command is pending at cell 40
    clear_mem;
    mem[40] = 11'h245;
    cmd_ready = 1'b0;
    arm_model;
    pulse_start(1'b0);
    wait_valid(200, "abort_wait");
    chk("abort_pending_addr", cmd_addr, 40);
    tick;
    hold = 1'b1;
    tick;
    hold = 1'b0;
    @(negedge clk);
    chk("abort_valid", cmd_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_object_count", object_count, 105);
    exp_q.delete();
    d0 = n_done;
    repeat (20) tick;
    chk("abort_no_done", n_done - d0, 0);
    cmd_ready = 1'b1;
    arm_model;
    pulse_start(1'b0);
    chk("rescan_from_zero", address_read_om, 0);
    chk("rescan_busy", busy, 1);
    wait_done(500, "rescan");
    chk("rescan_object_count", object_count, 1);

    // a second start mid-scan must not restart the pass
    clear_mem;
    mem[3] = 11'h001;
    mem[50] = 11'h480;
    mem[90] = 11'h77F;
    arm_model;
    a0 = n_acc;
    d0 = n_done;
    pulse_start(1'b0);
    repeat (49) tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(600, "overlap_scan");
    chk("overlap_done_cycle", done_cyc, 214);
    chk("overlap_accepts", n_acc - a0, 3);
    chk("overlap_object_count", object_count, 3);
    repeat (3) tick;
    chk("overlap_done_once", n_done - d0, 1);
    pulse_start(1'b1);
    repeat (4) begin
      chk("held_start_busy", busy, 0);
      tick;
    end
    chk("held_start_no_done", n_done - d0, 1);

    // reset in cycle 100 of a scan
    arm_model;
    pulse_start(1'b0);
    repeat (99) tick;
    reset = 1'b1;
    tick;
    chk_zero_outputs("midreset");
    reset = 1'b0;
    exp_q.delete();
    repeat (3) tick;
    chk("midreset_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
